flag_cond_unit: RTL
===================

Name: flag_cond_unit

Overview:
- Consumer side of the ALU flag interface: registers the N/Z/C/V flags produced by flag_calculator and answers condition-code queries against them for branch and conditional-execute logic.
- Queries use a valid/ready request and a valid/ready response with a one-entry registered output.
- Includes a small save/restore stack so interrupt or context-switch logic can preserve and restore flags.
- Sits between the ALU flag outputs and the sequencer.

Parameters:
- DEPTH, 4, number of entries in the flag save stack (at least 1).
- FORWARD, 1, 1 = a query accepted in the same cycle as a flag update or restore evaluates the next-state flags; 0 = it evaluates the currently registered flags.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- flag_we  input  1  load incoming flags this cycle.
- negative_in  input  1  N flag from flag_calculator.
- zero_in  input  1  Z flag from flag_calculator.
- cout_in  input  1  C flag from flag_calculator.
- overflow_in  input  1  V flag from flag_calculator.
- flags_out  output  4  registered flags, ordered {N,Z,C,V}.
- cond_valid  input  1  query request valid.
- cond_code  input  4  condition to evaluate.
- cond_ready  output  1  query can be accepted.
- cond_resp_valid  output  1  result valid.
- cond_true  output  1  condition result.
- cond_resp_ready  input  1  consumer takes result.
- push  input  1  save current flags.
- pop  input  1  restore flags from stack top.
- err_clr  input  1  clear stack_err.
- stack_full  output  1  count equals DEPTH.
- stack_empty  output  1  count equals 0.
- stack_err  output  1  sticky error: overflow, underflow or illegal push+pop.

Behaviour:
- Reset: when rst_n is low at a clk edge:
  - flags_out becomes 0000, cond_resp_valid 0, cond_true 0, stack count 0, stack_err 0.
  - stack_empty is therefore 1 and stack_full 0.
  - Any in-flight response is dropped; stack contents are don't-care.
- Flag register next-state precedence, highest first:
  - A valid pop (not empty, no simultaneous push) loads the stack-top flags.
  - Otherwise flag_we loads {negative_in,zero_in,cout_in,overflow_in}.
  - Otherwise the register holds.
  - When a valid pop and flag_we coincide, flag_we is discarded.
- Push writes the pre-update flags_out value. Push and flag_we in the same cycle are both performed.
- Pop when empty: ignored, stack_err set, flag_we still applies.
- Push when full: ignored, stack_err set.
- Push and pop in the same cycle: both ignored, stack_err set, flag_we still applies.
- stack_err is sticky until err_clr. If err_clr and a new error coincide, stack_err stays 1.
- Stack is LIFO. The count saturates at neither end because illegal operations are blocked. stack_full and stack_empty are decoded from the registered count.
- Query handshake:
  - cond_ready = !cond_resp_valid || cond_resp_ready (combinational).
  - Accept occurs on cond_valid && cond_ready.
  - On accept, cond_true is registered and cond_resp_valid is set on the next edge (latency 1).
  - Back-to-back accepts are sustained while cond_resp_ready is held high.
  - A response with cond_resp_ready low holds cond_true and cond_resp_valid stable.
  - With no accept and cond_resp_ready high, cond_resp_valid clears.
- Evaluated flags:
  - FORWARD=1: the next-state flags after the precedence rules above.
  - FORWARD=0: flags_out.
- Condition table (cond_code: result):
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z. A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V). E AL: 1. F NV: 0.

Test Plan:
- Reset then flag_we with N,Z,C,V = 0,1,1,0 → flags_out=0110 next cycle; query EQ (0x0) → cond_resp_valid=1 and cond_true=1 one cycle after accept; query HI (0x8) → cond_true=0.
- FORWARD=1 with flags 0000, flag_we carrying 1000 in the same cycle as a MI (0x4) query → cond_true=1. Repeat with FORWARD=0 → cond_true=0.
- Backpressure: accept GE (0xA) with flags 1001, hold cond_resp_ready=0 for 3 cycles → cond_ready=0, cond_true=1 stable, a second query is not accepted. Raise cond_resp_ready → the second query is accepted that cycle.
- DEPTH=4: push flags 0001, 0010, 0100, 1000 → stack_full=1. Fifth push → stack_err=1 and count stays 4. Four pops → flags_out 1000, 0100, 0010, 0001 in turn, then stack_empty=1.
- Pop on empty stack together with flag_we=1111 → stack_err=1 and flags_out=1111. Pop and flag_we together on a non-empty stack → restored value wins. err_clr → stack_err=0.
- Assert rst_n low while cond_resp_valid=1 and count=2 → next cycle cond_resp_valid=0, flags_out=0000, stack_empty=1.

Source files
------------

// File: rtl/flag_cond_unit.sv
// Registers ALU N/Z/C/V flags, answers condition-code queries over a valid/ready
// request/response pair, and keeps a small LIFO of saved flags for context switches.
module flag_cond_unit #(
  parameter int DEPTH   = 4,
  parameter int FORWARD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_we,
  input  logic       negative_in,
  input  logic       zero_in,
  input  logic       cout_in,
  input  logic       overflow_in,
  output logic [3:0] flags_out,
  input  logic       cond_valid,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       cond_resp_valid,
  output logic       cond_true,
  input  logic       cond_resp_ready,
  input  logic       push,
  input  logic       pop,
  input  logic       err_clr,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          resp_valid_q, resp_valid_d;
  logic          true_q, true_d;
  logic [3:0]    stack_q [DEPTH];
  logic [3:0]    stack_d [DEPTH];

  logic       push_ok, pop_ok, err_set, accept, res;
  logic [3:0] top, eval;
  logic       n, z, c, v;

  assign stack_full  = (cnt_q == CW'(DEPTH));
  assign stack_empty = (cnt_q == '0);
  assign flags_out   = flags_q;
  assign stack_err   = err_q;
  assign cond_resp_valid = resp_valid_q;
  assign cond_true   = true_q;
  assign cond_ready  = !resp_valid_q || cond_resp_ready;

  // Push and pop together is treated as illegal; neither takes effect.
  assign push_ok = push && !pop && !stack_full;
  assign pop_ok  = pop && !push && !stack_empty;
  assign err_set = (push && pop) || (pop && !push && stack_empty) || (push && !pop && stack_full);
  assign accept  = cond_valid && cond_ready;

  always_comb begin
    top     = '0;
    stack_d = stack_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) top = stack_q[i];
      if (push_ok && cnt_q == CW'(i)) stack_d[i] = flags_q;
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (pop_ok)       flags_d = top;
    else if (flag_we) flags_d = {negative_in, zero_in, cout_in, overflow_in};

    cnt_d = cnt_q;
    if (push_ok)     cnt_d = cnt_q + CW'(1);
    else if (pop_ok) cnt_d = cnt_q - CW'(1);

    err_d = (err_q && !err_clr) || err_set;
  end

  // Forwarding lets a query see a flag update landing on the same edge.
  assign eval = (FORWARD != 0) ? flags_d : flags_q;
  assign {n, z, c, v} = eval;

  always_comb begin
    res = 1'b0;
    case (cond_code)
      4'h0: res = z;
      4'h1: res = !z;
      4'h2: res = c;
      4'h3: res = !c;
      4'h4: res = n;
      4'h5: res = !n;
      4'h6: res = v;
      4'h7: res = !v;
      4'h8: res = c && !z;
      4'h9: res = !c || z;
      4'hA: res = (n == v);
      4'hB: res = (n != v);
      4'hC: res = !z && (n == v);
      4'hD: res = z || (n != v);
      4'hE: res = 1'b1;
      default: res = 1'b0;
    endcase
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    true_d       = true_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      true_d       = res;
    end else if (cond_resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      true_q       <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      true_q       <= true_d;
    end
  end

  // Saved entries need no reset; the count marks which are live.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end
endmodule
